spi_sclk_gen: RTL and testbench

Programmable, synthesizable SPI serial-clock generator for flash VIP and controller benches. It replaces the free-running behavioural T/2 clock toggler.
- Derives serial clock C from the system clock using a runtime half-period divider.
- Supports all four CPOL/CPHA modes.
- Emits bursts of exactly N serial-clock periods under a start/done handshake, with abort.
- Provides per-edge sample/shift strobes for the shift-register logic beside it.

---
 rtl/spi_sclk_gen_if.sv | 37 +++
 rtl/spi_sclk_gen.sv | 155 +++++++++++++++
 tb/tb_spi_sclk_gen.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_sclk_gen_if.sv
// ============================================================================
// Module : spi_sclk_gen_if
// Brief  : Request/config and serial-clock/status bundle for spi_sclk_gen.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface spi_sclk_gen_if #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
);
    logic             start;
    logic             stop;
    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] cycles;
    logic             cpol;
    logic             cpha;
    logic             C;
    logic             busy;
    logic             done;
    logic             aborted;
    logic             sample_stb;
    logic             shift_stb;
    logic [CNT_W-1:0] remaining;

    modport master (
        output start, stop, div, cycles, cpol, cpha,
        input  C, busy, done, aborted, sample_stb, shift_stb, remaining
    );

    modport slave (
        input  start, stop, div, cycles, cpol, cpha,
        output C, busy, done, aborted, sample_stb, shift_stb, remaining
    );
endinterface

`default_nettype wire

// File: rtl/spi_sclk_gen.sv
// ============================================================================
// Module : spi_sclk_gen
// Brief  : Programmable SPI serial-clock burst generator, all CPOL/CPHA modes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spi_sclk_gen #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
) (
    input  logic           clock,
    input  logic           reset,
    spi_sclk_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH0  = 2'd1,
        PH1  = 2'd2
    } state_t;

    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] DIV_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t           state,      state_nxt;
    logic [DIV_W-1:0] timer,      timer_nxt;
    logic [DIV_W-1:0] div_q,      div_nxt;
    logic [CNT_W-1:0] rem,        rem_nxt;
    logic             cpol_q,     cpol_nxt;
    logic             cpha_q,     cpha_nxt;
    logic             sclk,       sclk_nxt;
    logic             busy_q,     busy_nxt;
    logic             done_q,     done_nxt;
    logic             abort_q,    abort_nxt;
    logic             sample_q,   sample_nxt;
    logic             shift_q,    shift_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            timer    <= DIV_ZERO;
            div_q    <= DIV_ZERO;
            rem      <= CNT_ZERO;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            sclk     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            div_q    <= div_nxt;
            rem      <= rem_nxt;
            cpol_q   <= cpol_nxt;
            cpha_q   <= cpha_nxt;
            sclk     <= sclk_nxt;
            busy_q   <= busy_nxt;
            done_q   <= done_nxt;
            abort_q  <= abort_nxt;
            sample_q <= sample_nxt;
            shift_q  <= shift_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        div_nxt    = div_q;
        rem_nxt    = rem;
        cpol_nxt   = cpol_q;
        cpha_nxt   = cpha_q;
        sclk_nxt   = sclk;
        busy_nxt   = busy_q;
        done_nxt   = 1'b0;
        abort_nxt  = 1'b0;
        sample_nxt = 1'b0;
        shift_nxt  = 1'b0;

        case (state)
            IDLE: begin
                // Idle bus level follows the live cpol so the line is correct before a burst.
                sclk_nxt = bus.cpol;
                if (bus.start) begin
                    if (bus.cycles != CNT_ZERO) begin
                        div_nxt   = bus.div;
                        rem_nxt   = bus.cycles;
                        cpol_nxt  = bus.cpol;
                        cpha_nxt  = bus.cpha;
                        timer_nxt = bus.div;
                        busy_nxt  = 1'b1;
                        state_nxt = PH0;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end

            PH0, PH1: begin
                if (bus.stop) begin
                    // Abort outranks a coincident timer expiry.
                    state_nxt = IDLE;
                    sclk_nxt  = cpol_q;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    abort_nxt = 1'b1;
                    rem_nxt   = CNT_ZERO;
                    timer_nxt = DIV_ZERO;
                end else if (timer == DIV_ZERO) begin
                    timer_nxt = div_q;
                    if (state == PH0) begin
                        sclk_nxt   = ~cpol_q;
                        state_nxt  = PH1;
                        sample_nxt = ~cpha_q;
                        shift_nxt  = cpha_q;
                    end else begin
                        sclk_nxt   = cpol_q;
                        sample_nxt = cpha_q;
                        shift_nxt  = ~cpha_q;
                        rem_nxt    = rem - CNT_ONE;
                        if (rem == CNT_ONE) begin
                            state_nxt = IDLE;
                            busy_nxt  = 1'b0;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = PH0;
                        end
                    end
                end else begin
                    timer_nxt = timer - DIV_ONE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.C          = sclk;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.aborted    = abort_q;
    assign bus.sample_stb = sample_q;
    assign bus.shift_stb  = shift_q;
    assign bus.remaining  = rem;

endmodule

`default_nettype wire

// File: tb/tb_spi_sclk_gen.sv
// ============================================================================
// Module : tb_spi_sclk_gen
// Brief  : Self-checking bench for spi_sclk_gen (vector table + scoreboard).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_spi_sclk_gen;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    spi_sclk_gen_if #(.DIV_W(8), .CNT_W(16)) bus ();

    spi_sclk_gen #(.DIV_W(8), .CNT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        c;
        logic        busy;
        logic        done;
        logic        aborted;
        logic        sample;
        logic        shift;
        logic [15:0] rem;
    } out_t;

    typedef struct {
        int d;
        int n;
        bit p;
        bit h;
        bit with_stop;
        int exp_busy;
        int exp_strb;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic out_t dut_out();
        out_t o;
        o = {bus.C, bus.busy, bus.done, bus.aborted, bus.sample_stb, bus.shift_stb, bus.remaining};
        return o;
    endfunction

    // Closed-form expectation for relative cycle i after busy rises.
    function automatic out_t model(input int d, input int n, input bit p, input bit h, input int i);
        out_t o;
        int hp;
        int l;
        int m;
        hp = d + 1;
        l  = 2 * n * hp;
        m  = i / hp;
        o  = '0;
        o.c    = p ^ m[0];
        o.busy = (i < l);
        o.done = (i == l);
        if (i > 0 && (i % hp) == 0) begin
            o.sample = m[0] ? ~h : h;
            o.shift  = ~o.sample;
        end
        o.rem = 16'(n - i / (2 * hp));
        return o;
    endfunction

    task automatic run_burst(input int d, input int n, input bit p, input bit h,
                             input bit with_stop, input int stop_at,
                             input int restart_at, input int flip_at,
                             output int busy_cnt, output int samp_cnt, output int shift_cnt);
        out_t q[$];
        out_t e;
        out_t o;
        int   l;
        int   k;
        bit   final_p;
        bus.div    = d[7:0];
        bus.cycles = n[15:0];
        bus.cpol   = p;
        bus.cpha   = h;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        @(negedge clock);
        e = '0;
        e.c = p;
        chk($sformatf("idle_level_p%0d", p), dut_out(), e);

        final_p = (flip_at >= 0) ? ~p : p;
        l = 2 * n * (d + 1);
        if (stop_at >= 0) begin
            for (int i = 0; i <= stop_at; i++) q.push_back(model(d, n, p, h, i));
            e = '0;
            e.c = p;
            e.done = 1'b1;
            e.aborted = 1'b1;
            q.push_back(e);
        end else begin
            for (int i = 0; i <= l; i++) q.push_back(model(d, n, p, h, i));
        end
        e = '0;
        e.c = final_p;
        q.push_back(e);

        bus.start = 1'b1;
        bus.stop  = with_stop;
        @(negedge clock);
        bus.start = 1'b0;
        bus.stop  = 1'b0;

        k = 0;
        busy_cnt = 0;
        samp_cnt = 0;
        shift_cnt = 0;
        while (q.size() > 0) begin
            e = q.pop_front();
            o = dut_out();
            chk($sformatf("burst_d%0d_n%0d_i%0d", d, n, k), o, e);
            busy_cnt  += int'(o.busy);
            samp_cnt  += int'(o.sample);
            shift_cnt += int'(o.shift);
            bus.stop = (k == stop_at);
            if (k == restart_at) begin
                bus.start  = 1'b1;
                bus.cycles = 16'd5;
                bus.div    = 8'd0;
                bus.cpha   = ~h;
            end else begin
                bus.start = 1'b0;
            end
            if (k == flip_at) bus.cpol = ~p;
            k++;
            if (q.size() > 0) @(negedge clock);
        end
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    vec_t vecs[6];
    int   bc, sc, hc;
    out_t zero_o;

    initial begin
        vecs[0] = '{d:0, n:4, p:0, h:0, with_stop:0, exp_busy:8,  exp_strb:4};
        vecs[1] = '{d:2, n:3, p:1, h:1, with_stop:0, exp_busy:18, exp_strb:3};
        vecs[2] = '{d:0, n:0, p:0, h:0, with_stop:0, exp_busy:0,  exp_strb:0};
        vecs[3] = '{d:0, n:1, p:1, h:0, with_stop:0, exp_busy:2,  exp_strb:1};
        vecs[4] = '{d:3, n:2, p:0, h:1, with_stop:0, exp_busy:16, exp_strb:2};
        vecs[5] = '{d:1, n:3, p:1, h:0, with_stop:1, exp_busy:12, exp_strb:3};
        zero_o = '0;

        bus.start = 1'b0; bus.stop = 1'b0; bus.div = '0;
        bus.cycles = '0;  bus.cpol = 1'b0; bus.cpha = 1'b0;

        @(negedge clock);
        chk("reset_state", dut_out(), zero_o);
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            run_burst(vecs[v].d, vecs[v].n, vecs[v].p, vecs[v].h, vecs[v].with_stop,
                      -1, -1, -1, bc, sc, hc);
            chk($sformatf("vec%0d_busy_cycles", v), bc, vecs[v].exp_busy);
            chk($sformatf("vec%0d_samples", v), sc, vecs[v].exp_strb);
            chk($sformatf("vec%0d_shifts", v), hc, vecs[v].exp_strb);
        end

        // Abort one clock after the second leading edge, then a clean burst.
        run_burst(1, 8, 0, 0, 0, 6, -1, -1, bc, sc, hc);
        chk("abort_samples", sc, 2);
        chk("abort_shifts", hc, 1);
        run_burst(1, 8, 0, 0, 0, -1, -1, -1, bc, sc, hc);
        chk("post_abort_samples", sc, 8);
        chk("post_abort_busy", bc, 32);

        // Asynchronous reset while C is high in PH1.
        bus.div = 8'd3; bus.cycles = 16'd4; bus.cpol = 1'b0; bus.cpha = 1'b0;
        @(negedge clock);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (5) @(negedge clock);
        chk("pre_reset_ph1", dut_out(), model(3, 4, 0, 0, 5));
        #2 reset = 1'b1;
        #1 chk("async_reset_immediate", dut_out(), zero_o);
        @(negedge clock);
        chk("reset_hold_no_done", dut_out(), zero_o);
        reset = 1'b0;
        @(negedge clock);
        chk("after_reset_idle", dut_out(), zero_o);
        run_burst(3, 2, 0, 0, 0, -1, -1, -1, bc, sc, hc);
        chk("post_reset_periods", sc, 2);

        // Max divider, restart attempt and cpol flip mid-burst.
        run_burst(255, 1, 0, 0, 0, -1, 100, 300, bc, sc, hc);
        chk("maxdiv_busy", bc, 512);
        chk("maxdiv_samples", sc, 1);
        chk("maxdiv_shifts", hc, 1);
        @(negedge clock);
        zero_o.c = 1'b1;
        chk("maxdiv_single_done", dut_out(), zero_o);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
